// File: rtl/act_window_ctrl.sv
// Multi-rank ACT window controller: per-rank tFAW slot counters and tRRD spacing,
// with a round-robin arbiter placing at most one ACT per cycle on the shared slot.
module act_window_ctrl #(
    parameter int NUM_RANKS = 2,
    parameter int MAX_ACT   = 4,
    parameter int TFAW      = 10,
    parameter int TRRD      = 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [NUM_RANKS-1:0] ACTREQ,
    output logic [NUM_RANKS-1:0] ACTOK,
    output logic [NUM_RANKS-1:0] WindowFull
);
    localparam int SW = (TFAW > 1) ? $clog2(TFAW) : 1;
    localparam int RW = (TRRD > 1) ? $clog2(TRRD) : 1;
    localparam int PW = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1;
    localparam logic [SW-1:0] SLOT_LOAD = SW'(TFAW - 1);
    localparam logic [RW-1:0] RRD_LOAD  = RW'(TRRD - 1);

    logic [SW-1:0]        slot_q [NUM_RANKS][MAX_ACT];
    logic [SW-1:0]        slot_d [NUM_RANKS][MAX_ACT];
    logic [RW-1:0]        rrd_q  [NUM_RANKS];
    logic [RW-1:0]        rrd_d  [NUM_RANKS];
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [NUM_RANKS-1:0] has_free, eligible, grant, full_d, loaded;
    logic                 found;
    int                   idx;

    always_comb begin
        has_free = '0;
        eligible = '0;
        for (int r = 0; r < NUM_RANKS; r++) begin
            for (int s = 0; s < MAX_ACT; s++) begin
                if (slot_q[r][s] == '0) has_free[r] = 1'b1;
            end
            eligible[r] = ACTREQ[r] & has_free[r] & (rrd_q[r] == '0);
        end
    end

    // Round-robin scan starting at ptr_q; grants are suppressed while in reset.
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_RANKS; i++) begin
            idx = (int'(ptr_q) + i) % NUM_RANKS;
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                ptr_d      = PW'((idx + 1) % NUM_RANKS);
            end
        end
        if (!Reset) grant = '0;
    end

    assign ACTOK = grant;

    // Busy slots age by one; a grant claims the lowest free slot, which was 0 and so never decrements.
    always_comb begin
        loaded = '0;
        full_d = '1;
        for (int r = 0; r < NUM_RANKS; r++) begin
            rrd_d[r] = (rrd_q[r] != '0) ? rrd_q[r] - RW'(1) : rrd_q[r];
            if (grant[r]) rrd_d[r] = RRD_LOAD;
            for (int s = 0; s < MAX_ACT; s++) begin
                slot_d[r][s] = (slot_q[r][s] != '0) ? slot_q[r][s] - SW'(1) : slot_q[r][s];
                if (grant[r] && !loaded[r] && slot_q[r][s] == '0) begin
                    slot_d[r][s] = SLOT_LOAD;
                    loaded[r]    = 1'b1;
                end
                if (slot_d[r][s] == '0) full_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int r = 0; r < NUM_RANKS; r++) begin
                rrd_q[r] <= '0;
                for (int s = 0; s < MAX_ACT; s++) slot_q[r][s] <= '0;
            end
            ptr_q      <= '0;
            WindowFull <= '0;
        end else begin
            for (int r = 0; r < NUM_RANKS; r++) begin
                rrd_q[r] <= rrd_d[r];
                for (int s = 0; s < MAX_ACT; s++) slot_q[r][s] <= slot_d[r][s];
            end
            ptr_q      <= ptr_d;
            WindowFull <= full_d;
        end
    end
endmodule

// File: tb/tb_act_window_ctrl.sv
// Bench for act_window_ctrl: two configurations checked each cycle against a
// grant-history model, plus literal schedules and random-run safety properties.
module tb_act_window_ctrl;
    localparam int LM = 16383;

    logic       Clock = 1'b0;
    logic       rst_a, rst_b;
    logic [1:0] req_a, ok_a, wf_a;
    logic [3:0] req_b, ok_b, wf_b;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int t0, t1;

    int cfg_nr[2] = '{2, 4};
    int cfg_ma[2] = '{4, 2};
    int cfg_tf[2] = '{10, 6};
    int cfg_tr[2] = '{2, 1};

    // model: grant times per rank, last grant time, round-robin pointer
    int gq[2][4][$];
    int mlast[2][4];
    int mptr[2];
    // property tracking on the DUT's own grants
    int dq[2][4][$];
    int dlast[2][4];
    int waitc[2][4];
    int viol_onehot = 0, viol_window = 0, viol_rrd = 0, viol_starve = 0;

    logic [3:0] glog_a[16384], wlog_a[16384], glog_b[16384], wlog_b[16384];
    logic [3:0] eok_a, ewf_a, eok_b, ewf_b;

    act_window_ctrl dut_a (
        .Clock(Clock), .Reset(rst_a), .ACTREQ(req_a), .ACTOK(ok_a), .WindowFull(wf_a)
    );

    act_window_ctrl #(.NUM_RANKS(4), .MAX_ACT(2), .TFAW(6), .TRRD(1)) dut_b (
        .Clock(Clock), .Reset(rst_b), .ACTREQ(req_b), .ACTOK(ok_b), .WindowFull(wf_b)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, got, exp);
    endtask

    // A rank is full when MAX_ACT of its grants fall in the last TFAW-1 cycles.
    task automatic model_step(input int d, input logic rst, input logic [3:0] req,
                              output logic [3:0] eok, output logic [3:0] ewf);
        int nr, ma, tf, tr, k;
        logic [3:0] elig;
        nr = cfg_nr[d]; ma = cfg_ma[d]; tf = cfg_tf[d]; tr = cfg_tr[d];
        eok = '0; ewf = '0; elig = '0;
        if (!rst) begin
            for (int r = 0; r < 4; r++) begin
                gq[d][r].delete();
                mlast[d][r] = -1000;
            end
            mptr[d] = 0;
            return;
        end
        for (int r = 0; r < nr; r++) begin
            while (gq[d][r].size() > 0 && gq[d][r][0] <= cyc - tf) void'(gq[d][r].pop_front());
            if (gq[d][r].size() >= ma) ewf[r] = 1'b1;
            if (req[r] && !ewf[r] && (cyc - mlast[d][r] >= tr)) elig[r] = 1'b1;
        end
        for (int i = 0; i < nr; i++) begin
            k = (mptr[d] + i) % nr;
            if (elig[k]) begin
                eok[k] = 1'b1;
                gq[d][k].push_back(cyc);
                mlast[d][k] = cyc;
                mptr[d] = (k + 1) % nr;
                break;
            end
        end
    endtask

    task automatic prop_step(input int d, input logic rst, input logic [3:0] req, input logic [3:0] ok);
        int nr, ma, tf, tr;
        nr = cfg_nr[d]; ma = cfg_ma[d]; tf = cfg_tf[d]; tr = cfg_tr[d];
        if (!rst) begin
            for (int r = 0; r < 4; r++) begin
                dq[d][r].delete();
                dlast[d][r] = -1000;
                waitc[d][r] = 0;
            end
            return;
        end
        if ($countones(ok) > 1) viol_onehot++;
        for (int r = 0; r < nr; r++) begin
            while (dq[d][r].size() > 0 && dq[d][r][0] <= cyc - tf) void'(dq[d][r].pop_front());
            if (ok[r]) begin
                if (cyc - dlast[d][r] < tr) viol_rrd++;
                dq[d][r].push_back(cyc);
                if (dq[d][r].size() > ma) viol_window++;
                dlast[d][r] = cyc;
                waitc[d][r] = 0;
            end else if (req[r]) begin
                waitc[d][r]++;
                if (waitc[d][r] > nr * (tf + tr)) viol_starve++;
            end else begin
                waitc[d][r] = 0;
            end
        end
    endtask

    always @(negedge Clock) begin
        model_step(0, rst_a, {2'b00, req_a}, eok_a, ewf_a);
        model_step(1, rst_b, req_b, eok_b, ewf_b);
        check("ACTOK_a", int'(ok_a), int'(eok_a[1:0]));
        check("WindowFull_a", int'(wf_a), int'(ewf_a[1:0]));
        check("ACTOK_b", int'(ok_b), int'(eok_b));
        check("WindowFull_b", int'(wf_b), int'(ewf_b));
        prop_step(0, rst_a, {2'b00, req_a}, {2'b00, ok_a});
        prop_step(1, rst_b, req_b, ok_b);
        glog_a[cyc & LM] = {2'b00, ok_a};
        wlog_a[cyc & LM] = {2'b00, wf_a};
        glog_b[cyc & LM] = ok_b;
        wlog_b[cyc & LM] = wf_b;
        cyc++;
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; req_a = '0; req_b = '0;
        repeat (3) step();

        // rank0 alone: 4-then-stall pattern
        step(); rst_a = 1'b1; req_a = 2'b01; t0 = cyc;
        repeat (20) step();
        step(); req_a = '0; rst_a = 1'b0;
        for (int k = 0; k <= 20; k++)
            check($sformatf("s1_grant k=%0d", k), int'(glog_a[(t0 + k) & LM][0]),
                  (k inside {0, 2, 4, 6, 10, 12, 14, 16, 20}) ? 1 : 0);
        for (int k = 6; k <= 10; k++)
            check($sformatf("s1_full k=%0d", k), int'(wlog_a[(t0 + k) & LM][0]),
                  (k inside {7, 8, 9}) ? 1 : 0);

        // both ranks alternate, then both stall until their windows reopen
        step(); rst_a = 1'b1; req_a = 2'b11; t0 = cyc;
        repeat (11) step();
        step(); req_a = '0; rst_a = 1'b0;
        for (int k = 0; k <= 11; k++)
            check($sformatf("s2_grant k=%0d", k), int'(glog_a[(t0 + k) & LM]),
                  (k < 8) ? (1 << (k % 2)) : (k == 10) ? 1 : (k == 11) ? 2 : 0);

        // short burst: tRRD gap
        step(); rst_a = 1'b1; req_a = 2'b01; t0 = cyc;
        step(); step();
        step(); req_a = '0;
        step(); rst_a = 1'b0;
        check("s3_grant k=0", int'(glog_a[t0 & LM]), 1);
        check("s3_grant k=1", int'(glog_a[(t0 + 1) & LM]), 0);
        check("s3_grant k=2", int'(glog_a[(t0 + 2) & LM]), 1);

        // reset while the window is full, request held across it
        step(); rst_a = 1'b1; req_a = 2'b01; t0 = cyc;
        repeat (8) step();
        rst_a = 1'b0;
        step(); rst_a = 1'b1; t1 = cyc;
        repeat (10) step();
        step(); req_a = '0; rst_a = 1'b0;
        check("s4_full_before", int'(wlog_a[(t0 + 7) & LM][0]), 1);
        check("s4_ok_in_reset", int'(glog_a[(t0 + 8) & LM]), 0);
        check("s4_full_in_reset", int'(wlog_a[(t0 + 8) & LM]), 0);
        for (int k = 0; k <= 10; k++)
            check($sformatf("s4_grant k=%0d", k), int'(glog_a[(t1 + k) & LM][0]),
                  (k inside {0, 2, 4, 6, 10}) ? 1 : 0);

        // 4-rank config: rank2 alone
        step(); rst_b = 1'b1; req_b = 4'b0100; t0 = cyc;
        repeat (13) step();
        step(); req_b = '0; rst_b = 1'b0;
        for (int k = 0; k <= 13; k++)
            check($sformatf("s5_grant k=%0d", k), int'(glog_b[(t0 + k) & LM]),
                  (k inside {0, 1, 6, 7, 12, 13}) ? 4 : 0);

        // ranks 0,2,3: pointer wraps from 3 back to 0
        step(); rst_b = 1'b1; req_b = 4'b1101; t0 = cyc;
        repeat (5) step();
        step(); req_b = '0; rst_b = 1'b0;
        for (int k = 0; k <= 5; k++)
            check($sformatf("s6_grant k=%0d", k), int'(glog_b[(t0 + k) & LM]),
                  (k % 3 == 0) ? 1 : (k % 3 == 1) ? 4 : 8);

        // random traffic; requests mostly held until granted
        step(); rst_a = 1'b1; rst_b = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            step();
            for (int r = 0; r < 2; r++) begin
                if (req_a[r]) begin
                    if (glog_a[(cyc - 1) & LM][r]) req_a[r] = ($urandom_range(99) < 50);
                    else if ($urandom_range(99) < 2) req_a[r] = 1'b0;
                end else req_a[r] = ($urandom_range(99) < 40);
            end
            for (int r = 0; r < 4; r++) begin
                if (req_b[r]) begin
                    if (glog_b[(cyc - 1) & LM][r]) req_b[r] = ($urandom_range(99) < 50);
                    else if ($urandom_range(99) < 2) req_b[r] = 1'b0;
                end else req_b[r] = ($urandom_range(99) < 40);
            end
            rst_a = (i != 5000);
            rst_b = (i != 5000);
        end
        step();
        check("onehot_violations", viol_onehot, 0);
        check("window_violations", viol_window, 0);
        check("rrd_violations", viol_rrd, 0);
        check("starvation_violations", viol_starve, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/act_window_ctrl.md
Name: act_window_ctrl

Overview:
Multi-rank DRAM activate-window controller that grants ACT commands onto a single shared command slot. Per rank it enforces two limits: at most MAX_ACT activates in any TFAW consecutive cycles (tFAW), and a minimum spacing of TRRD cycles between activates (tRRD). Across ranks, a round-robin arbiter issues at most one ACT per cycle. It sits between the per-rank bank schedulers and the command issue stage.

Parameters:
NUM_RANKS, 2, number of independent ranks/requesters (>=1)
MAX_ACT, 4, maximum ACTs per rank within any TFAW-cycle window (>=1)
TFAW, 10, window length in cycles (>=1)
TRRD, 2, minimum cycles between consecutive ACTs to the same rank (>=1)

Ports:
Clock  input  1  clock, all state on rising edge
Reset  input  1  asynchronous, active-low reset
ACTREQ  input  NUM_RANKS  per-rank activate request, level, held until granted
ACTOK  output  NUM_RANKS  per-rank grant, combinational, one-hot or zero
WindowFull  output  NUM_RANKS  registered; all MAX_ACT window slots of that rank busy

Behaviour:
- Grant: ACT for rank r is issued in a cycle when ACTREQ[r] & ACTOK[r]. Grant state updates on that cycle's closing rising edge.
- Reset low: all slot counters = 0, rrd counters = 0, RR pointer = 0, WindowFull = 0. ACTOK is forced to 0 combinationally while Reset is low.
- Reset mid-operation: all history is discarded. The first request after release is grantable in its first cycle.
- Window slots: each rank has MAX_ACT down-counters of width $clog2(TFAW) (minimum 1 bit).
  - A slot is free when it is 0.
  - On a grant, the lowest-index free slot loads TFAW-1.
  - Each other nonzero slot decrements by 1 per cycle.
  - If load and decrement apply to the same slot on the same edge, load wins.
  - Result: an ACT in cycle t occupies its slot through cycle t+TFAW-1, and the slot is free in cycle t+TFAW.
- tRRD counter: per rank, width $clog2(TRRD) (minimum 1 bit).
  - Loads TRRD-1 on a grant; otherwise decrements while nonzero.
  - TRRD=1 allows back-to-back ACTs to the same rank.
- Eligible[r] = ACTREQ[r] & (at least one free slot) & (rrd counter == 0).
- Arbitration: the first eligible rank scanning from ptr, ptr+1, ... wrapping modulo NUM_RANKS is granted.
  - ptr updates to (granted+1) mod NUM_RANKS on a grant; otherwise it holds.
  - No eligible rank: ACTOK = 0.
- An ACTREQ that is dropped without a grant has no effect on state.
- WindowFull[r]: registered; equals "no free slot" as computed from next-state slot values.
- Simultaneous events: one slot freeing and a new grant in the same cycle is allowed. The freed slot is reusable in that cycle.
- TFAW=1: slots never block; only tRRD and arbitration limit grants.
- Starvation bound: a continuously requesting rank is granted within NUM_RANKS*(TFAW+TRRD) cycles.

Test Plan:
- Defaults; rank0 ACTREQ held high from cycle 0, rank1 idle.
  - Required: ACTOK[0] in cycles 0,2,4,6,10,12,14,16,20.
  - Required: WindowFull[0]=1 during cycles 7-9.
- Defaults; both ranks held high.
  - Required grants: r0@0, r1@1, r0@2, r1@3, r0@4, r1@5, r0@6, r1@7.
  - Required: none in cycles 8-9; r0@10, r1@11.
- Defaults; rank0 request in cycles 0-2.
  - Required: granted @0, ACTOK[0]=0 @1 (tRRD), granted @2.
- Scenario 1, Reset pulled low in cycle 8 (window full).
  - Required: ACTOK=0 and WindowFull=0 immediately.
  - Required: after release, a held request is granted in the first cycle and the 4-then-stall pattern restarts.
- NUM_RANKS=4, MAX_ACT=2, TFAW=6, TRRD=1; rank2 held high.
  - Required: grants @0,1,6,7,12,13.
  - Required: pointer wrap verified with ranks 3 and 0 also requesting.
- 10000 cycles of random ACTREQ against a scoreboard. Required:
  - at most MAX_ACT grants per rank in every TFAW-cycle window;
  - grant spacing of at least TRRD cycles per rank;
  - at most one ACTOK bit set per cycle;
  - starvation bound respected.
